// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: watches the lamp drives of a two-way intersection
// controller, tracks the phase sequence and yellow dwell, and latches the
// first violation seen until it is explicitly cleared.
module traffic_light_monitor #(
  parameter int unsigned YEL_MIN = 3,
  parameter int unsigned YEL_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       NS_Red,
  input  logic       NS_Yellow,
  input  logic       NS_Green,
  input  logic       EW_Red,
  input  logic       EW_Yellow,
  input  logic       EW_Green,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] phase,
  output logic [7:0] cycle_count,
  output logic       locked
);

  typedef enum logic [1:0] {StSync, StTrack, StFault} state_e;

  localparam logic [1:0] PhNsg = 2'd0;
  localparam logic [1:0] PhEwy = 2'd3;

  localparam logic [2:0] CodeNone     = 3'd0;
  localparam logic [2:0] CodeLamp     = 3'd1;
  localparam logic [2:0] CodeConflict = 3'd2;
  localparam logic [2:0] CodeSequence = 3'd3;
  localparam logic [2:0] CodeYelShort = 3'd4;
  localparam logic [2:0] CodeYelLong  = 3'd5;

  localparam logic [7:0] YelMin = YEL_MIN[7:0];
  localparam logic [7:0] YelMax = YEL_MAX[7:0];

  state_e     state_q, state_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] cnt_q, cnt_d;

  logic       lamp_ok;
  logic       legal;
  logic [1:0] dec_phase;
  logic [1:0] phase_adv;
  logic       in_yellow;
  logic [2:0] viol;

  // Sample classification: one lamp per direction, and exactly one direction red.
  always_comb begin
    lamp_ok   = $onehot({NS_Red, NS_Yellow, NS_Green}) && $onehot({EW_Red, EW_Yellow, EW_Green});
    legal     = lamp_ok && (NS_Red ^ EW_Red);
    dec_phase = 2'd3;
    if (NS_Green)       dec_phase = 2'd0;
    else if (NS_Yellow) dec_phase = 2'd1;
    else if (EW_Green)  dec_phase = 2'd2;
    // Phase encoding is ordered so the only legal advance is +1 modulo 4.
    phase_adv = phase_q + 2'd1;
    in_yellow = phase_q[0];
  end

  // Next-state: checks per FSM state, lowest violation code wins.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    viol    = CodeNone;

    // Phase output follows every legal sample and holds across illegal ones.
    if (legal) phase_d = dec_phase;

    case (state_q)
      StSync: begin
        if (!lamp_ok)    viol = CodeLamp;
        else if (!legal) viol = CodeConflict;
        else begin
          dwell_d = 8'd1;
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (!lamp_ok)    viol = CodeLamp;
        else if (!legal) viol = CodeConflict;
        else if (dec_phase == phase_q) begin
          // Flag overlong yellow on the sample that would push dwell past the limit.
          if (in_yellow && dwell_q >= YelMax) viol = CodeYelLong;
          else if (dwell_q != 8'hff)          dwell_d = dwell_q + 8'd1;
        end else if (dec_phase == phase_adv) begin
          if (in_yellow && dwell_q < YelMin) viol = CodeYelShort;
          else begin
            dwell_d = 8'd1;
            if (phase_q == PhEwy && cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
          end
        end else begin
          viol = CodeSequence;
        end
      end
      StFault: begin
        // Checks suspended; the sample on the clearing edge is not checked.
        if (fault_clr) begin
          fault_d = 1'b0;
          code_d  = CodeNone;
          state_d = StSync;
        end
      end
      default: state_d = StSync;
    endcase

    if (viol != CodeNone) begin
      fault_d = 1'b1;
      code_d  = viol;
      state_d = StFault;
    end
  end

  // State registers with synchronous reset that discards all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSync;
      fault_q <= 1'b0;
      code_q  <= CodeNone;
      phase_q <= PhNsg;
      dwell_q <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign phase       = phase_q;
  assign cycle_count = cnt_q;
  assign locked      = (state_q == StTrack);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       NS_Red, NS_Yellow, NS_Green;
  logic       EW_Red, EW_Yellow, EW_Green;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic [7:0] cycle_count;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_monitor #(.YEL_MIN(3), .YEL_MAX(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .NS_Red      (NS_Red),
    .NS_Yellow   (NS_Yellow),
    .NS_Green    (NS_Green),
    .EW_Red      (EW_Red),
    .EW_Yellow   (EW_Yellow),
    .EW_Green    (EW_Green),
    .fault_clr   (fault_clr),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .cycle_count (cycle_count),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive lamps {Red,Yellow,Green} per direction for n edges; sample 1ns after each edge.
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input int n);
    for (int i = 0; i < n; i++) begin
      {NS_Red, NS_Yellow, NS_Green} = ns;
      {EW_Red, EW_Yellow, EW_Green} = ew;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_code"},  32'(fault_code), 0);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_cnt"},   32'(cycle_count), 0);
    chk({tag, "_lock"},  32'(locked), 0);
  endtask

  initial begin
    rst = 1'b1;
    fault_clr = 1'b0;
    step(G, R, 2);
    chk_all_zero("reset");
    rst = 1'b0;

    // Legal sequence, one full cycle.
    step(G, R, 1);
    chk("seq_lock_first", 32'(locked), 1);
    step(G, R, 9);
    step(Y, R, 4);
    step(R, G, 10);
    step(R, Y, 4);
    chk("seq_fault_mid", 32'(fault), 0);
    chk("seq_phase_ewy", 32'(phase), 3);
    chk("seq_cnt_before", 32'(cycle_count), 0);
    step(G, R, 1);
    chk("seq_cnt", 32'(cycle_count), 1);
    chk("seq_phase_end", 32'(phase), 0);
    chk("seq_fault_end", 32'(fault), 0);
    chk("seq_lock_end", 32'(locked), 1);

    // Both greens: conflict, held, then cleared and relocked.
    step(G, G, 1);
    chk("conf_fault", 32'(fault), 1);
    chk("conf_code", 32'(fault_code), 2);
    chk("conf_lock", 32'(locked), 0);
    chk("conf_phase_hold", 32'(phase), 0);
    step(G, R, 2);
    chk("conf_hold_fault", 32'(fault), 1);
    chk("conf_hold_code", 32'(fault_code), 2);
    fault_clr = 1'b1;
    step(G, R, 1);
    fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 0);
    chk("clr_code", 32'(fault_code), 0);
    chk("clr_lock", 32'(locked), 0);
    step(G, R, 1);
    chk("relock", 32'(locked), 1);
    chk("cnt_retained", 32'(cycle_count), 1);

    // NSG -> EWG skip: sequence error.
    step(R, G, 1);
    chk("skip_code", 32'(fault_code), 3);
    fault_clr = 1'b1;
    step(G, R, 1);
    fault_clr = 1'b0;
    step(G, R, 1);
    // NS green+yellow with EW green too: lamp beats conflict.
    step(3'b011, G, 1);
    chk("lamp_fault", 32'(fault), 1);
    chk("lamp_code", 32'(fault_code), 1);
    chk("lamp_cnt_kept", 32'(cycle_count), 1);

    // Short yellow: NSY 2 cycles then EWG.
    fault_clr = 1'b1;
    step(G, R, 1);
    fault_clr = 1'b0;
    step(G, R, 1);
    step(Y, R, 2);
    chk("short_pre", 32'(fault), 0);
    step(R, G, 1);
    chk("short_code", 32'(fault_code), 4);

    // Long yellow: EWY held, fault on 9th sample.
    fault_clr = 1'b1;
    step(R, Y, 1);
    fault_clr = 1'b0;
    step(R, Y, 8);
    chk("long_pre_fault", 32'(fault), 0);
    chk("long_pre_phase", 32'(phase), 3);
    chk("long_pre_lock", 32'(locked), 1);
    step(R, Y, 1);
    chk("long_fault", 32'(fault), 1);
    chk("long_code", 32'(fault_code), 5);

    // Yellow of exactly YEL_MIN and YEL_MAX is legal.
    fault_clr = 1'b1;
    step(G, R, 1);
    fault_clr = 1'b0;
    step(G, R, 1);
    step(Y, R, 3);
    step(R, G, 1);
    chk("min_fault", 32'(fault), 0);
    chk("min_phase", 32'(phase), 2);
    step(R, Y, 3);
    step(G, R, 1);
    chk("min_cnt", 32'(cycle_count), 2);
    step(Y, R, 8);
    step(R, G, 1);
    chk("max_fault", 32'(fault), 0);
    step(R, Y, 8);
    step(G, R, 1);
    chk("max_fault2", 32'(fault), 0);
    chk("max_cnt", 32'(cycle_count), 3);

    // Saturation of cycle_count.
    for (int c = 0; c < 251; c++) begin
      step(Y, R, 3);
      step(R, G, 1);
      step(R, Y, 3);
      step(G, R, 1);
    end
    chk("sat_254", 32'(cycle_count), 254);
    for (int c = 0; c < 3; c++) begin
      step(Y, R, 3);
      step(R, G, 1);
      step(R, Y, 3);
      step(G, R, 1);
      chk("sat_255", 32'(cycle_count), 255);
    end
    chk("sat_fault", 32'(fault), 0);

    // Reset mid-cycle.
    step(Y, R, 2);
    rst = 1'b1;
    step(Y, R, 1);
    rst = 1'b0;
    chk_all_zero("midrst");

    // Fault, then rst with fault_clr together.
    step(G, R, 1);
    step(R, G, 1);
    chk("pre_rst_fault", 32'(fault), 1);
    rst = 1'b1;
    fault_clr = 1'b1;
    step(G, R, 1);
    rst = 1'b0;
    fault_clr = 1'b0;
    chk_all_zero("rstclr");
    step(G, R, 1);
    chk("post_rst_lock", 32'(locked), 1);
    chk("post_rst_fault", 32'(fault), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
